// File: rtl/perm_out_serializer.sv
// Serializes each finished 1600-bit Keccak state (plus tag) into 8 consecutive 200-bit beats.
// A one-entry pending buffer absorbs a result that arrives mid-frame; anything beyond that is dropped and flagged.
module perm_out_serializer #(
  parameter int BEATS  = 8,
  parameter int BEAT_W = 200,
  parameter int TAG_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pushin,
  input  logic [BEATS*BEAT_W-1:0] din,
  input  logic [TAG_W-1:0]        tagin,
  output logic [BEAT_W-1:0]       dout,
  output logic [2:0]              doutix,
  output logic [TAG_W-1:0]        tagout,
  output logic                    pushout,
  output logic                    overflow
);
  localparam int DATA_W = BEATS * BEAT_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t              st;
  logic [DATA_W-1:0]   act_data_p0;
  logic [TAG_W-1:0]    act_tag_p0;
  logic [DATA_W-1:0]   pend_data_p0;
  logic [TAG_W-1:0]    pend_tag_p0;
  logic                pend_vld_p0;

  logic                last;
  logic                load_act_din;
  logic                load_act_pend;
  logic                load_pend;
  logic                clr_pend;
  logic                drop;
  logic                emit;
  logic [2:0]          emit_ix;
  logic [DATA_W-1:0]   src_data;
  logic [TAG_W-1:0]    src_tag;

  function automatic logic [BEAT_W-1:0] beat_sel(input logic [DATA_W-1:0] s, input logic [2:0] ix);
    return s[int'(ix)*BEAT_W +: BEAT_W];
  endfunction

  assign last = pushout && (doutix == 3'(BEATS - 1));

  always_comb begin
    load_act_din  = 1'b0;
    load_act_pend = 1'b0;
    load_pend     = 1'b0;
    clr_pend      = 1'b0;
    drop          = 1'b0;
    emit          = 1'b0;
    emit_ix       = 3'd0;
    case (st)
      IDLE: begin
        load_act_din = pushin;
      end
      SEND: begin
        if (last) begin
          // Frame boundary: next frame starts on the very next beat, pending first.
          if (pend_vld_p0) begin
            load_act_pend = 1'b1;
            emit          = 1'b1;
            load_pend     = pushin;
            clr_pend      = !pushin;
          end else if (pushin) begin
            load_act_din = 1'b1;
            emit         = 1'b1;
          end
        end else begin
          emit    = 1'b1;
          emit_ix = pushout ? 3'(doutix + 3'd1) : 3'd0;
          if (pushin) begin
            if (pend_vld_p0) drop = 1'b1;
            else             load_pend = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // The first beat of a frame may come straight from pending or din, bypassing ACTIVE.
  always_comb begin
    src_data = act_data_p0;
    src_tag  = act_tag_p0;
    if (load_act_pend) begin
      src_data = pend_data_p0;
      src_tag  = pend_tag_p0;
    end else if (st == SEND && load_act_din) begin
      src_data = din;
      src_tag  = tagin;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      pend_vld_p0 <= 1'b0;
      pushout     <= 1'b0;
      doutix      <= 3'd0;
      dout        <= '0;
      tagout      <= '0;
      overflow    <= 1'b0;
    end else begin
      if (st == IDLE && pushin)
        st <= SEND;
      else if (st == SEND && last && !pend_vld_p0 && !pushin)
        st <= IDLE;
      if (load_pend)     pend_vld_p0 <= 1'b1;
      else if (clr_pend) pend_vld_p0 <= 1'b0;
      if (drop) overflow <= 1'b1;
      if (emit) begin
        pushout <= 1'b1;
        doutix  <= emit_ix;
        dout    <= beat_sel(src_data, emit_ix);
        tagout  <= src_tag;
      end else begin
        pushout <= 1'b0;
        doutix  <= 3'd0;
        dout    <= '0;
        tagout  <= '0;
      end
    end
  end

  // Buffer contents carry no reset; their valid state lives in the control block.
  always_ff @(posedge clk) begin
    if (load_act_din) begin
      act_data_p0 <= din;
      act_tag_p0  <= tagin;
    end else if (load_act_pend) begin
      act_data_p0 <= pend_data_p0;
      act_tag_p0  <= pend_tag_p0;
    end
    if (load_pend) begin
      pend_data_p0 <= din;
      pend_tag_p0  <= tagin;
    end
  end

endmodule
